// File: rtl/debouncer_pkg.sv
// Shared definitions for the multi-channel debouncer.
// - deb_state_e: per-channel FSM encoding. The two transitional states are
//   "wait" states in delayed mode and "lockout" states in early mode.
// - ModeDelayed / ModeEarly: values for the MODE parameter.
package debouncer_pkg;

    typedef enum logic [1:0] {
        StStableLo = 2'd0,
        StWaitHi   = 2'd1,  // LOCK_HI in early mode
        StStableHi = 2'd2,
        StWaitLo   = 2'd3   // LOCK_LO in early mode
    } deb_state_e;

    localparam int unsigned ModeDelayed = 0;
    localparam int unsigned ModeEarly   = 1;

endpackage

// File: rtl/debouncer_channel.sv
// Single-bit debouncer: synchroniser chain, 4-state FSM, saturating timer and
// registered rise/fall strobes.
// Ports:
//   clk       - clock, rising edge
//   reset_n   - synchronous active-low reset
//   noisy     - raw asynchronous input
//   debounced - clean registered level
//   rise      - one-cycle strobe on debounced 0->1
//   fall      - one-cycle strobe on debounced 1->0
module debouncer_channel
    import debouncer_pkg::*;
#(
    parameter int unsigned SAT_VALUE   = 1_999_999,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MODE        = ModeDelayed,
    parameter bit          INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisy,
    output logic debounced,
    output logic rise,
    output logic fall
);

    localparam int unsigned    CntW   = $clog2(SAT_VALUE + 1);
    localparam logic [CntW-1:0] SatCnt = CntW'(SAT_VALUE);
    localparam bit             Early  = (MODE == ModeEarly);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_e             state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
            state_q <= INIT_LEVEL ? StStableHi : StStableLo;
            cnt_q   <= '0;
            deb_q   <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], noisy};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StStableLo: begin
                cnt_d = '0;
                if (s) begin
                    state_d = StWaitHi;
                    // Early mode commits on the first edge, then locks out.
                    if (Early) begin
                        deb_d  = 1'b1;
                        rise_d = 1'b1;
                    end
                end
            end
            StWaitHi: begin
                if (!Early && !s) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end else if (cnt_q == SatCnt) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                    if (!Early) begin
                        deb_d  = 1'b1;
                        rise_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStableHi: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = StWaitLo;
                    if (Early) begin
                        deb_d  = 1'b0;
                        fall_d = 1'b1;
                    end
                end
            end
            StWaitLo: begin
                if (!Early && s) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end else if (cnt_q == SatCnt) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                    if (!Early) begin
                        deb_d  = 1'b0;
                        fall_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    assign debounced = deb_q;
    assign rise      = rise_q;
    assign fall      = fall_q;

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: CHANNELS independent debouncer_channel instances.
// Ports:
//   clk       - clock, rising edge
//   reset_n   - synchronous active-low reset
//   noisy     - raw asynchronous inputs, one per channel
//   debounced - clean registered levels
//   rise      - per-channel one-cycle strobe on debounced 0->1
//   fall      - per-channel one-cycle strobe on debounced 1->0
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SAT_VALUE   = 1_999_999,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MODE        = ModeDelayed,
    parameter bit          INIT_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debouncer_channel #(
            .SAT_VALUE  (SAT_VALUE),
            .SYNC_STAGES(SYNC_STAGES),
            .MODE       (MODE),
            .INIT_LEVEL (INIT_LEVEL)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .noisy    (noisy[i]),
            .debounced(debounced[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
module tb_debouncer_multi;

    localparam int Sat  = 9;
    localparam int Sync = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] noisy_del, noisy_early;
    logic [3:0] deb_del, rise_del, fall_del;
    logic [3:0] deb_early, rise_early, fall_early;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debouncer_multi #(
        .CHANNELS(4), .SAT_VALUE(Sat), .SYNC_STAGES(Sync), .MODE(0), .INIT_LEVEL(1'b0)
    ) u_dut_del (
        .clk(clk), .reset_n(reset_n), .noisy(noisy_del),
        .debounced(deb_del), .rise(rise_del), .fall(fall_del)
    );

    debouncer_multi #(
        .CHANNELS(4), .SAT_VALUE(Sat), .SYNC_STAGES(Sync), .MODE(1), .INIT_LEVEL(1'b0)
    ) u_dut_early (
        .clk(clk), .reset_n(reset_n), .noisy(noisy_early),
        .debounced(deb_early), .rise(rise_early), .fall(fall_early)
    );

    // Reference model: input delay line, then per channel either a run-length
    // count of disagreeing samples (delayed) or a lockout countdown (early).
    logic [3:0] m_hist [2][Sync];
    logic [3:0] m_deb  [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    int         m_cnt  [2][4];

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] nz, input logic rn);
        m_rise[d] = '0;
        m_fall[d] = '0;
        if (!rn) begin
            for (int j = 0; j < Sync; j++) m_hist[d][j] = '0;
            m_deb[d] = '0;
            for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                logic v;
                logic tog;
                v   = m_hist[d][Sync-1][c];
                tog = 1'b0;
                if (d == 0) begin
                    // Needs Sat+2 consecutive disagreeing samples.
                    if (v != m_deb[d][c]) begin
                        m_cnt[d][c]++;
                        if (m_cnt[d][c] == Sat + 2) begin
                            tog         = 1'b1;
                            m_cnt[d][c] = 0;
                        end
                    end else begin
                        m_cnt[d][c] = 0;
                    end
                end else begin
                    if (m_cnt[d][c] > 0) begin
                        m_cnt[d][c]--;
                    end else if (v != m_deb[d][c]) begin
                        tog         = 1'b1;
                        m_cnt[d][c] = Sat + 1;
                    end
                end
                if (tog) begin
                    m_deb[d][c] = ~m_deb[d][c];
                    if (m_deb[d][c]) m_rise[d][c] = 1'b1;
                    else             m_fall[d][c] = 1'b1;
                end
            end
            for (int j = Sync - 1; j > 0; j--) m_hist[d][j] = m_hist[d][j-1];
            m_hist[d][0] = nz;
        end
    endtask

    task automatic step(input logic [3:0] nd, input logic [3:0] ne);
        noisy_del   = nd;
        noisy_early = ne;
        @(posedge clk);
        model_step(0, nd, reset_n);
        model_step(1, ne, reset_n);
        #1;
        check4("model_del_deb",    deb_del,    m_deb[0]);
        check4("model_del_rise",   rise_del,   m_rise[0]);
        check4("model_del_fall",   fall_del,   m_fall[0]);
        check4("model_early_deb",  deb_early,  m_deb[1]);
        check4("model_early_rise", rise_early, m_rise[1]);
        check4("model_early_fall", fall_early, m_fall[1]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step(4'h0, 4'h0);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] nz;
        int         reps;
        logic [3:0] deb;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int         rcnt;
        logic [3:0] rd, re;

        // Delayed: ch0 clean rise/fall, then ch3 falling with ch0 rising together.
        tbl[0]  = '{4'b0001, 12, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'b0001,  1, 4'h1, 4'h1, 4'h0};
        tbl[2]  = '{4'b0001,  1, 4'h1, 4'h0, 4'h0};
        tbl[3]  = '{4'b0001,  2, 4'h1, 4'h0, 4'h0};
        tbl[4]  = '{4'b0000, 12, 4'h1, 4'h0, 4'h0};
        tbl[5]  = '{4'b0000,  1, 4'h0, 4'h0, 4'h1};
        tbl[6]  = '{4'b0000,  1, 4'h0, 4'h0, 4'h0};
        tbl[7]  = '{4'b1000, 12, 4'h0, 4'h0, 4'h0};
        tbl[8]  = '{4'b1000,  1, 4'h8, 4'h8, 4'h0};
        tbl[9]  = '{4'b1000,  2, 4'h8, 4'h0, 4'h0};
        tbl[10] = '{4'b0001, 12, 4'h8, 4'h0, 4'h0};
        tbl[11] = '{4'b0001,  1, 4'h1, 4'h1, 4'h8};
        tbl[12] = '{4'b0001,  1, 4'h1, 4'h0, 4'h0};

        // Reset held with all inputs high.
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 4'hF);
            check4("rst_deb", deb_del | deb_early, 4'h0);
            check4("rst_strobe", rise_del | fall_del | rise_early | fall_early, 4'h0);
        end
        reset_n = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step(4'hF, 4'hF);
            if (i == 2) begin
                check4("rst_early_deb", deb_early, 4'hF);
                check4("rst_early_rise", rise_early, 4'hF);
            end
            if (i == 11) check4("rst_del_deb_e11", deb_del, 4'h0);
            if (i == 12) begin
                check4("rst_del_deb_e12", deb_del, 4'hF);
                check4("rst_del_rise_e12", rise_del, 4'hF);
            end
        end
        step(4'hF, 4'hF);
        check4("rst_del_rise_once", rise_del, 4'h0);

        // Table-driven delayed sequences.
        do_reset();
        for (int r = 0; r < 13; r++) begin
            repeat (tbl[r].reps) step(tbl[r].nz, 4'h0);
            check4($sformatf("tbl%0d_deb", r), deb_del, tbl[r].deb);
            check4($sformatf("tbl%0d_rise", r), rise_del, tbl[r].rise);
            check4($sformatf("tbl%0d_fall", r), fall_del, tbl[r].fall);
        end

        // Delayed bounce on ch1: high 5, low 1, high 20.
        do_reset();
        rcnt = 0;
        for (int i = 0; i < 26; i++) begin
            step((i == 5) ? 4'b0000 : 4'b0010, 4'h0);
            if (rise_del[1]) rcnt++;
            if (i == 17) check4("bounce_deb_e17", deb_del, 4'h0);
            if (i == 18) begin
                check4("bounce_deb_e18", deb_del, 4'b0010);
                check4("bounce_rise_e18", rise_del, 4'b0010);
            end
        end
        check4("bounce_rise_count", 4'(rcnt), 4'd1);

        // Early mode ch2: edge, 8 cycles of bounce, then low.
        do_reset();
        rcnt = 0;
        for (int i = 0; i < 16; i++) begin
            logic b;
            b = (i == 0) ? 1'b1 : ((i <= 8) ? ((i % 2) == 0) : 1'b0);
            step(4'h0, {1'b0, b, 2'b00});
            if (rise_early[2]) rcnt++;
            if (i == 2) begin
                check4("early_deb_e2", deb_early, 4'b0100);
                check4("early_rise_e2", rise_early, 4'b0100);
            end
            if (i == 12) begin
                check4("early_deb_e12", deb_early, 4'b0100);
                check4("early_fall_e12", fall_early, 4'h0);
            end
            if (i == 13) begin
                check4("early_deb_e13", deb_early, 4'h0);
                check4("early_fall_e13", fall_early, 4'b0100);
            end
        end
        check4("early_rise_count", 4'(rcnt), 4'd1);

        // Reset at count 5 of a delayed WAIT_HI on ch0.
        do_reset();
        for (int i = 0; i < 8; i++) step(4'b0001, 4'h0);
        reset_n = 1'b0;
        repeat (2) step(4'b0001, 4'h0);
        check4("midrst_deb", deb_del, 4'h0);
        check4("midrst_rise", rise_del, 4'h0);
        reset_n = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step(4'b0001, 4'h0);
            if (i == 11) check4("midrst_deb_e11", deb_del, 4'h0);
            if (i == 12) begin
                check4("midrst_deb_e12", deb_del, 4'b0001);
                check4("midrst_rise_e12", rise_del, 4'b0001);
            end
        end

        // Random slow-toggling inputs with occasional resets.
        do_reset();
        rd = '0;
        re = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 11) == 0) rd[c] = ~rd[c];
                if ($urandom_range(0, 11) == 0) re[c] = ~re[c];
            end
            reset_n = ($urandom_range(0, 399) != 0);
            step(rd, re);
        end
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
